// File: rtl/crc16_frame_arb.sv
// rtl/crc16_frame_arb.sv - two-requester frame arbiter appending a CRC-16 (0x8005) trailer
module crc16_frame_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        out_src,
  output logic [15:0] crc,
  output logic        crc_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PASS, CRC_HI, CRC_LO} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [15:0] wcrc_q, wcrc_d;
  logic [15:0] crc_q, crc_d;
  logic        crc_done_q, crc_done_d;

  logic [7:0]  sel_data;
  logic        sel_valid;
  logic        sel_last;

  // MSB-first, unreflected, one full byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign sel_data  = gnt_q ? req1_data  : req0_data;
  assign sel_valid = gnt_q ? req1_valid : req0_valid;
  assign sel_last  = gnt_q ? req1_last  : req0_last;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wcrc_d     = wcrc_q;
    crc_d      = crc_q;
    crc_done_d = 1'b0;
    out_data   = 8'h00;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // on a tie, the requester that did not finish the previous frame wins
          gnt_d   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          wcrc_d  = 16'h0000;
          state_d = PASS;
        end
      end
      PASS: begin
        out_data   = sel_data;
        out_valid  = sel_valid;
        req0_ready = ~gnt_q & out_ready;
        req1_ready =  gnt_q & out_ready;
        if (sel_valid && out_ready) begin
          wcrc_d = crc16_byte(wcrc_q, sel_data);
          if (sel_last) state_d = CRC_HI;
        end
      end
      CRC_HI: begin
        out_data  = wcrc_q[15:8];
        out_valid = 1'b1;
        if (out_ready) state_d = CRC_LO;
      end
      CRC_LO: begin
        out_data  = wcrc_q[7:0];
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) begin
          crc_d      = wcrc_q;
          crc_done_d = 1'b1;
          last_d     = gnt_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wcrc_q     <= 16'h0000;
      crc_q      <= 16'h0000;
      crc_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wcrc_q     <= wcrc_d;
      crc_q      <= crc_d;
      crc_done_q <= crc_done_d;
    end
  end

  assign out_src  = gnt_q;
  assign crc      = crc_q;
  assign crc_done = crc_done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_crc16_frame_arb.sv
// tb/tb_crc16_frame_arb.sv - directed self-checking bench for crc16_frame_arb
module tb_crc16_frame_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req0_data, req1_data;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_ready, out_src;
  logic [15:0] crc;
  logic        crc_done, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] f0[$];
  logic [7:0] f1[$];
  logic [7:0] obytes[$];
  logic       osrc[$];
  logic       olast[$];
  int         otime[$];

  crc16_frame_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .out_src(out_src), .crc(crc), .crc_done(crc_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (crc_done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      obytes.push_back(out_data);
      osrc.push_back(out_src);
      olast.push_back(out_last);
      otime.push_back(cyc);
    end
    if (prev_stall && out_valid && out_data !== prev_data) stab_err++;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic clear_mon();
    obytes.delete(); osrc.delete(); olast.delete(); otime.delete();
  endtask

  task automatic drive(input int src);
    int n, g;
    logic hs;
    n = (src != 0) ? f1.size() : f0.size();
    for (int i = 0; i < n; i++) begin
      if (src == 0) begin req0_valid = 1; req0_data = f0[i]; req0_last = (i == n - 1); end
      else          begin req1_valid = 1; req1_data = f1[i]; req1_last = (i == n - 1); end
      g = 0; hs = 0;
      while (!hs && g < 1000) begin
        @(negedge clk);
        hs = (src != 0) ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        @(posedge clk); #1;
        g++;
      end
      checks++;
      if (!hs) begin
        errors++;
        $display("FAIL drive_handshake src=%0d byte=%0d got=none need=handshake", src, i);
        break;
      end
    end
    if (src == 0) begin req0_valid = 0; req0_last = 0; end
    else          begin req1_valid = 0; req1_last = 0; end
  endtask

  task automatic wait_done(input int tgt);
    int g = 0;
    while (done_cnt < tgt && g < 3000) begin @(posedge clk); g++; end
    checks++;
    if (done_cnt < tgt) begin
      errors++;
      $display("FAIL wait_crc_done got=%0d need=%0d", done_cnt, tgt);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 1;
    req0_data = 0; req0_valid = 0; req0_last = 0;
    req1_data = 0; req1_valid = 0; req1_last = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({busy, out_valid, out_last, crc_done, req0_ready, req1_ready, out_src} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b need=0000000",
               {busy, out_valid, out_last, crc_done, req0_ready, req1_ready, out_src});
    end
    checks++;
    if (crc !== 16'h0000) begin errors++; $display("FAIL reset_crc got=%h need=0000", crc); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h need=00", out_data); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_check_string();
    logic [7:0] e[11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hFE, 8'hE8};
    int base;
    logic srcbad, lastbad;
    base = done_cnt; clear_mon(); out_ready = 1;
    f0 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    drive(0);
    wait_done(base + 1);
    checks++;
    if (obytes.size() != 11) begin errors++; $display("FAIL str_len got=%0d need=11", obytes.size()); end
    else begin
      srcbad = 0; lastbad = 0;
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (obytes[i] !== e[i]) begin errors++; $display("FAIL str_byte%0d got=%h need=%h", i, obytes[i], e[i]); end
        if (osrc[i] !== 1'b0) srcbad = 1;
        if (olast[i] !== (i == 10)) lastbad = 1;
      end
      checks++;
      if (srcbad) begin errors++; $display("FAIL str_src got=1 need=0"); end
      checks++;
      if (lastbad) begin errors++; $display("FAIL str_last got=misplaced need=only_on_crc_lo"); end
    end
    checks++;
    if (crc !== 16'hFEE8) begin errors++; $display("FAIL str_crc got=%h need=fee8", crc); end
    checks++;
    if (done_cnt != base + 1) begin errors++; $display("FAIL str_done_pulses got=%0d need=1", done_cnt - base); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL str_idle_busy got=%b need=0", busy); end
  endtask

  task automatic test_single_byte();
    int base;
    base = done_cnt; clear_mon(); out_ready = 1;
    f0 = '{8'h01};
    drive(0);
    wait_done(base + 1);
    checks++;
    if (crc !== 16'h8005) begin errors++; $display("FAIL one01_crc got=%h need=8005", crc); end
    checks++;
    if (obytes.size() != 3 || obytes[0] !== 8'h01 || obytes[1] !== 8'h80 || obytes[2] !== 8'h05 || olast[2] !== 1'b1) begin
      errors++; $display("FAIL one01_stream got_len=%0d need=01,80,05 last", obytes.size());
    end
    clear_mon();
    f0 = '{8'h00};
    drive(0);
    wait_done(base + 2);
    checks++;
    if (crc !== 16'h0000) begin errors++; $display("FAIL one00_crc got=%h need=0000", crc); end
    checks++;
    if (obytes.size() != 3 || obytes[0] !== 8'h00 || obytes[1] !== 8'h00 || obytes[2] !== 8'h00) begin
      errors++; $display("FAIL one00_stream got_len=%0d need=00,00,00", obytes.size());
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] e1[6] = '{8'h01, 8'h80, 8'h05, 8'h00, 8'h00, 8'h00};
    logic [7:0] e2[6] = '{8'h02, 8'h80, 8'h0F, 8'h03, 8'h00, 8'h0A};
    int base;
    clear_mon(); out_ready = 1;
    f0 = '{8'h01}; f1 = '{8'h00};
    rst_n = 0; done_cnt = 0; base = 0;
    fork
      begin repeat (3) @(posedge clk); #2; rst_n = 1; end
      drive(0);
      drive(1);
    join
    wait_done(base + 2);
    checks++;
    if (obytes.size() != 6) begin errors++; $display("FAIL arb1_len got=%0d need=6", obytes.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obytes[i] !== e1[i] || osrc[i] !== (i >= 3)) begin
          errors++; $display("FAIL arb1_byte%0d got=%h/src%0d need=%h/src%0d", i, obytes[i], osrc[i], e1[i], (i >= 3));
        end
      end
      checks++;
      if (otime[3] - otime[2] != 2) begin
        errors++; $display("FAIL back_to_back_gap got=%0d need=2", otime[3] - otime[2]);
      end
    end
    checks++;
    if (crc !== 16'h0000) begin errors++; $display("FAIL arb1_crc got=%h need=0000", crc); end

    clear_mon();
    f0 = '{8'h02}; f1 = '{8'h03};
    fork
      drive(0);
      drive(1);
    join
    wait_done(base + 4);
    checks++;
    if (obytes.size() != 6) begin errors++; $display("FAIL arb2_len got=%0d need=6", obytes.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obytes[i] !== e2[i] || osrc[i] !== (i >= 3)) begin
          errors++; $display("FAIL arb2_byte%0d got=%h/src%0d need=%h/src%0d", i, obytes[i], osrc[i], e2[i], (i >= 3));
        end
      end
    end
    checks++;
    if (crc !== 16'h000A) begin errors++; $display("FAIL arb2_crc got=%h need=000a", crc); end
  endtask

  task automatic test_stall();
    logic [7:0] e[11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hFE, 8'hE8};
    int base;
    base = done_cnt; clear_mon(); stab_err = 0;
    f0 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fork
      drive(0);
      begin
        int g = 0;
        while (done_cnt < base + 1 && g < 3000) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
          g++;
        end
        out_ready = 1;
      end
    join
    wait_done(base + 1);
    checks++;
    if (obytes.size() != 11) begin errors++; $display("FAIL stall_len got=%0d need=11", obytes.size()); end
    else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (obytes[i] !== e[i]) begin errors++; $display("FAIL stall_byte%0d got=%h need=%h", i, obytes[i], e[i]); end
      end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL stall_stable got=%0d changes need=0", stab_err); end
    checks++;
    if (crc !== 16'hFEE8) begin errors++; $display("FAIL stall_crc got=%h need=fee8", crc); end
  endtask

  task automatic test_reset_midframe();
    int i, g, base;
    logic hs;
    clear_mon(); out_ready = 1; base = done_cnt;
    f0 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    i = 0; g = 0;
    req0_valid = 1; req0_last = 0;
    while (i < 4 && g < 200) begin
      req0_data = f0[i];
      @(negedge clk);
      hs = req0_valid && req0_ready;
      @(posedge clk); #1;
      if (hs) i++;
      g++;
    end
    checks++;
    if (i != 4) begin errors++; $display("FAIL mid_setup got=%0d bytes need=4", i); end
    rst_n = 0;
    #1;
    checks++;
    if ({busy, out_valid, out_last, crc_done, req0_ready, req1_ready, out_src} !== 7'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset_outputs got=%b/%h need=0000000/00",
                         {busy, out_valid, out_last, crc_done, req0_ready, req1_ready, out_src}, out_data);
    end
    checks++;
    if (crc !== 16'h0000) begin errors++; $display("FAIL mid_reset_crc got=%h need=0000", crc); end
    req0_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (obytes.size() != 4 || done_cnt != base) begin
      errors++; $display("FAIL mid_abandon got=%0d bytes/%0d done need=4/0", obytes.size(), done_cnt - base);
    end
    rst_n = 1;
    @(posedge clk); #1;
    clear_mon();
    drive(0);
    wait_done(base + 1);
    checks++;
    if (crc !== 16'hFEE8 || obytes.size() != 11) begin
      errors++; $display("FAIL mid_recover got=%h/%0d need=fee8/11", crc, obytes.size());
    end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_single_byte();
    test_arbitration();
    test_stall();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc16_frame_arb.md
CRC16_FRAME_ARB -- requirements
Module: crc16_frame_arb

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req0_data  in  8  requester 0 frame byte.
REQ-005 req0_valid  in  1  requester 0 byte available.
REQ-006 req0_last  in  1  requester 0 byte is last of frame.
REQ-007 req0_ready  out  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-008 req1_data, req1_valid, req1_last, req1_ready: same directions, widths and meanings as REQ-004..007, for requester 1.
REQ-009 out_data  out  8  output stream byte (payload, then CRC high, then CRC low).
REQ-010 out_valid  out  1  out_data valid.
REQ-011 out_last  out  1  marks the CRC low byte.
REQ-012 out_ready  in  1  downstream accepts byte when high with out_valid.
REQ-013 out_src  out  1  index of the granted requester; held for the whole frame including CRC bytes.
REQ-014 crc  out  16  CRC of the last completed frame.
REQ-015 crc_done  out  1  one-cycle pulse when crc updates.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The CRC SHALL be CRC-16: polynomial 0x8005, init 0x0000, MSB-first, no reflection, no final XOR. It processes 8 bits per accepted byte in one cycle.
REQ-018 The FSM SHALL have states IDLE, PASS, CRC_HI and CRC_LO.
REQ-019 IDLE behaviour:
- All readies are 0 and out_valid is 0.
- If any reqN_valid is high, grant a requester and move to PASS next cycle; the working CRC clears to 0x0000.
- No byte is transferred in the IDLE cycle.
REQ-020 Arbitration SHALL be round-robin at frame granularity.
- With one requester valid, that requester is granted.
- With both valid, the requester not granted last is granted.
- The grant pointer updates only on frame completion.
REQ-021 PASS behaviour (combinational pass-through of the granted requester):
- out_data, out_valid and out_last=0 follow the granted requester.
- Granted reqN_ready = out_ready; the ungranted requester's ready is 0.
REQ-022 In PASS, each handshake (valid and ready both high) SHALL update the working CRC with that byte.
REQ-023 A handshake with reqN_last=1 in PASS SHALL move the FSM to CRC_HI next cycle.
REQ-024 CRC_HI SHALL drive out_data = working CRC[15:8] with out_valid=1 and out_last=0, and advance to CRC_LO on out_ready.
REQ-025 CRC_LO SHALL drive out_data = working CRC[7:0] with out_valid=1 and out_last=1. On out_ready:
- load crc with the working CRC;
- pulse crc_done for one cycle;
- record the grant;
- return to IDLE.
REQ-026 The minimum frame is one byte; frames SHALL have no maximum length.
REQ-027 Once out_valid is asserted in CRC_HI or CRC_LO, out_data SHALL stay stable until the handshake.
REQ-028 Inputs on the ungranted requester SHALL be ignored. reqN_valid dropping mid-frame SHALL stall the frame without error.
REQ-029 Back-to-back frames SHALL incur exactly one IDLE cycle between the CRC_LO handshake and the next payload byte.

Reset
REQ-030 While rst_n=0, the block SHALL hold:
- state=IDLE;
- working CRC and crc = 0x0000;
- crc_done=0, busy=0, all readies 0, out_valid=0, out_last=0, out_data=0x00, out_src=0;
- grant pointer = "last granted = 1", so req0 wins the first tie.
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately: no CRC bytes are emitted and crc is not updated.

Verification
REQ-032 req0 sends ASCII "123456789" (0x31..0x39, last on 0x39) with out_ready=1 -> out stream is 9 payload bytes, then 0xFE, then 0xE8 with out_last=1; crc=0xFEE8; crc_done pulses once.
REQ-033 Single-byte frames: 0x01 gives CRC bytes 0x80, 0x05 and crc=0x8005; 0x00 gives crc=0x0000.
REQ-034 Both requesters hold a frame valid from reset -> req0's frame completes first and req1's follows with out_src=1. A further simultaneous request then grants req0 again.
REQ-035 Toggle out_ready randomly during payload and CRC bytes -> no byte is lost or duplicated, out_data is stable while stalled, and the final crc matches REQ-032.
REQ-036 Assert rst_n=0 after the 4th byte of "123456789" -> outputs take the reset values at once. A new frame "123456789" after release gives crc=0xFEE8.
